// File: rtl/zbuf_writeback.sv
// rtl/zbuf_writeback.sv - Z-buffer write-back FIFO with pending-write lookup
// Optional same-address coalescing into the youngest entry: ZBUF_WB_COALESCE_EN
module zbuf_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          z_write_en,
  input  logic          frag_valid,
  output logic          frag_ready,
  input  logic [AW-1:0] frag_addr,
  input  logic [15:0]   frag_z,
  input  logic [AW-1:0] lkp_addr,
  output logic          lkp_hit,
  output logic [15:0]   lkp_z,
  output logic          sram_req,
  output logic [AW-1:0] sram_addr,
  output logic [15:0]   sram_wdata,
  input  logic          sram_ready,
  input  logic          flush,
  output logic          flush_done,
  output logic          idle
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_t;

  logic [AW-1:0] mem_addr [DEPTH];
  logic [15:0]   mem_z    [DEPTH];

  state_t        state, state_n;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_n, rd_n, count;
  logic [IW-1:0] head_idx_n, lkp_idx;
  logic [AW-1:0] head_addr_n;
  logic [15:0]   head_z_n;
  logic          full, push, pop, alloc, coalesce, empty_n;

  assign count = wr_ptr - rd_ptr;
  assign full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

`ifdef ZBUF_WB_COALESCE_EN
  logic [IW-1:0] tail_idx;
  logic          tail_match;

  assign tail_idx = wr_ptr[IW-1:0] - IW'(1);
  // The head being presented is never rewritten, so its write data stays stable.
  assign tail_match = (count != '0) && (mem_addr[tail_idx] == frag_addr) &&
                      !((tail_idx == rd_ptr[IW-1:0]) && sram_req);
  assign frag_ready = (!full || tail_match) && (state != S_FLUSH);
  assign coalesce   = push && tail_match;
`else
  assign frag_ready = !full && (state != S_FLUSH);
  assign coalesce   = 1'b0;
`endif

  assign push    = frag_valid && frag_ready && z_write_en;
  assign alloc   = push && !coalesce;
  assign pop     = sram_req && sram_ready;
  assign wr_n    = wr_ptr + PW'(alloc);
  assign rd_n    = rd_ptr + PW'(pop);
  assign empty_n = (wr_n == rd_n);
  assign idle    = (count == '0) && (state == S_IDLE);

  // Next head contents, bypassing this cycle's write so the output register never lags.
  always_comb begin
    head_idx_n  = rd_n[IW-1:0];
    head_addr_n = mem_addr[head_idx_n];
    head_z_n    = mem_z[head_idx_n];
    if (alloc && (wr_ptr == rd_n)) begin
      head_addr_n = frag_addr;
      head_z_n    = frag_z;
    end
`ifdef ZBUF_WB_COALESCE_EN
    if (coalesce && (tail_idx == head_idx_n)) head_z_n = frag_z;
`endif
  end

  always_comb begin
    state_n    = state;
    flush_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (alloc) state_n = flush ? S_FLUSH : S_ACTIVE;
        else if (flush) flush_done = 1'b1;
      end
      S_ACTIVE: begin
        if (empty_n) begin
          state_n    = S_IDLE;
          flush_done = flush;
        end else if (flush) begin
          state_n = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (empty_n) begin
          state_n    = S_IDLE;
          flush_done = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      state      <= S_IDLE;
      sram_req   <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      wr_ptr   <= wr_n;
      rd_ptr   <= rd_n;
      state    <= state_n;
      sram_req <= !empty_n;
      if (!empty_n) begin
        sram_addr  <= head_addr_n;
        sram_wdata <= head_z_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      mem_addr[wr_ptr[IW-1:0]] <= frag_addr;
      mem_z[wr_ptr[IW-1:0]]    <= frag_z;
    end
`ifdef ZBUF_WB_COALESCE_EN
    else if (coalesce) begin
      mem_z[tail_idx] <= frag_z;
    end
`endif
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    lkp_hit = 1'b0;
    lkp_z   = '0;
    lkp_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lkp_idx = rd_ptr[IW-1:0] + IW'(i);
      if ((PW'(i) < count) && (mem_addr[lkp_idx] == lkp_addr)) begin
        lkp_hit = 1'b1;
        lkp_z   = mem_z[lkp_idx];
      end
    end
  end

endmodule

// File: tb/tb_zbuf_writeback.sv
// tb/tb_zbuf_writeback.sv - directed self-checking bench for zbuf_writeback
module tb_zbuf_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        z_write_en = 1'b1;
  logic        frag_valid = 1'b0;
  logic        frag_ready;
  logic [23:0] frag_addr = '0;
  logic [15:0] frag_z = '0;
  logic [23:0] lkp_addr = '0;
  logic        lkp_hit;
  logic [15:0] lkp_z;
  logic        sram_req;
  logic [23:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_ready = 1'b0;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        idle;

  int n_cmp = 0;
  int n_fail = 0;

  logic [23:0] wq_addr[$];
  logic [15:0] wq_z[$];

  zbuf_writeback #(.DEPTH(4), .AW(24)) dut (
    .clk(clk), .rst_n(rst_n), .z_write_en(z_write_en),
    .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_addr(frag_addr), .frag_z(frag_z),
    .lkp_addr(lkp_addr), .lkp_hit(lkp_hit), .lkp_z(lkp_z),
    .sram_req(sram_req), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_ready(sram_ready), .flush(flush), .flush_done(flush_done), .idle(idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && sram_req && sram_ready) begin
      wq_addr.push_back(sram_addr);
      wq_z.push_back(sram_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [23:0] a, input logic [15:0] z);
    frag_valid = 1'b1;
    frag_addr  = a;
    frag_z     = z;
    tick();
    frag_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    sram_ready = 1'b1;
    for (int k = 0; k < 12 && sram_req; k++) tick();
    sram_ready = 1'b0;
    n_cmp++;
    if (sram_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s drain_timeout sram_req=%b required 0", name, sram_req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_cmp += 8;
    if (frag_ready !== 1'b1) begin n_fail++; $display("FAIL reset frag_ready got %b want 1", frag_ready); end
    if (sram_req !== 1'b0) begin n_fail++; $display("FAIL reset sram_req got %b want 0", sram_req); end
    if (sram_addr !== 24'h0) begin n_fail++; $display("FAIL reset sram_addr got %h want 0", sram_addr); end
    if (sram_wdata !== 16'h0) begin n_fail++; $display("FAIL reset sram_wdata got %h want 0", sram_wdata); end
    if (lkp_hit !== 1'b0) begin n_fail++; $display("FAIL reset lkp_hit got %b want 0", lkp_hit); end
    if (lkp_z !== 16'h0) begin n_fail++; $display("FAIL reset lkp_z got %h want 0", lkp_z); end
    if (flush_done !== 1'b0) begin n_fail++; $display("FAIL reset flush_done got %b want 0", flush_done); end
    if (idle !== 1'b1) begin n_fail++; $display("FAIL reset idle got %b want 1", idle); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    wq_addr.delete(); wq_z.delete();
    sram_ready = 1'b1;
    push_one(24'h000010, 16'h1234);
    n_cmp += 4;
    if (sram_req !== 1'b1) begin n_fail++; $display("FAIL single req_n1 got %b want 1", sram_req); end
    if (sram_addr !== 24'h000010) begin n_fail++; $display("FAIL single addr got %h want 000010", sram_addr); end
    if (sram_wdata !== 16'h1234) begin n_fail++; $display("FAIL single wdata got %h want 1234", sram_wdata); end
    if (idle !== 1'b0) begin n_fail++; $display("FAIL single idle_n1 got %b want 0", idle); end
    tick();
    sram_ready = 1'b0;
    n_cmp += 3;
    if (sram_req !== 1'b0) begin n_fail++; $display("FAIL single req_n2 got %b want 0", sram_req); end
    if (idle !== 1'b1) begin n_fail++; $display("FAIL single idle_n2 got %b want 1", idle); end
    if (wq_addr.size() != 1) begin n_fail++; $display("FAIL single writes got %0d want 1", wq_addr.size()); end
  endtask

  task automatic test_fill();
    wq_addr.delete(); wq_z.delete();
    sram_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(24'h000100 + 24'(i), 16'hA000 + 16'(i));
    n_cmp++;
    if (frag_ready !== 1'b0) begin n_fail++; $display("FAIL fill frag_ready_full got %b want 0", frag_ready); end
    for (int s = 0; s < 2; s++) begin
      tick();
      n_cmp += 2;
      if (sram_addr !== 24'h000100) begin n_fail++; $display("FAIL fill stall_addr got %h want 000100", sram_addr); end
      if (sram_wdata !== 16'hA000) begin n_fail++; $display("FAIL fill stall_wdata got %h want a000", sram_wdata); end
    end
    sram_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp += 2;
      if (sram_req !== 1'b1) begin n_fail++; $display("FAIL fill burst_req%0d got %b want 1", i, sram_req); end
      if (sram_addr !== 24'h000100 + 24'(i)) begin n_fail++; $display("FAIL fill burst_addr%0d got %h want %h", i, sram_addr, 24'h000100 + 24'(i)); end
      tick();
    end
    sram_ready = 1'b0;
    n_cmp += 2;
    if (sram_req !== 1'b0) begin n_fail++; $display("FAIL fill req_after got %b want 0", sram_req); end
    if (wq_addr.size() != 4) begin n_fail++; $display("FAIL fill writes got %0d want 4", wq_addr.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (wq_z[i] !== 16'hA000 + 16'(i)) begin n_fail++; $display("FAIL fill order%0d got %h want %h", i, wq_z[i], 16'hA000 + 16'(i)); end
    end
  endtask

  task automatic test_lookup();
    wq_addr.delete(); wq_z.delete();
    sram_ready = 1'b0;
    lkp_addr   = 24'h000020;
    frag_valid = 1'b1; frag_addr = 24'h000020; frag_z = 16'h0100;
    #1;
    n_cmp++;
    if (lkp_hit !== 1'b0) begin n_fail++; $display("FAIL lookup same_cycle_hit got %b want 0", lkp_hit); end
    tick();
    frag_z = 16'h0050;
    tick();
    frag_valid = 1'b0;
    #1;
    n_cmp += 2;
    if (lkp_hit !== 1'b1) begin n_fail++; $display("FAIL lookup hit got %b want 1", lkp_hit); end
    if (lkp_z !== 16'h0050) begin n_fail++; $display("FAIL lookup youngest_z got %h want 0050", lkp_z); end
    lkp_addr = 24'h000021;
    #1;
    n_cmp++;
    if (lkp_hit !== 1'b0) begin n_fail++; $display("FAIL lookup miss got %b want 0", lkp_hit); end
    drain("lookup");
    n_cmp++;
    if (wq_z.size() != 2) begin n_fail++; $display("FAIL lookup writes got %0d want 2", wq_z.size()); end
    else begin
      n_cmp++;
      if (wq_z[1] !== 16'h0050) begin n_fail++; $display("FAIL lookup last_z got %h want 0050", wq_z[1]); end
    end
  endtask

  task automatic test_no_zwrite();
    z_write_en = 1'b0;
    frag_valid = 1'b1; frag_addr = 24'h000777; frag_z = 16'h7777;
    #1;
    n_cmp++;
    if (frag_ready !== 1'b1) begin n_fail++; $display("FAIL nozw frag_ready got %b want 1", frag_ready); end
    tick();
    frag_valid = 1'b0;
    z_write_en = 1'b1;
    tick();
    n_cmp += 2;
    if (sram_req !== 1'b0) begin n_fail++; $display("FAIL nozw sram_req got %b want 0", sram_req); end
    if (idle !== 1'b1) begin n_fail++; $display("FAIL nozw idle got %b want 1", idle); end
  endtask

  task automatic test_flush();
    int pulses;
    pulses = 0;
    flush = 1'b1;
    #1;
    n_cmp++;
    if (flush_done !== 1'b1) begin n_fail++; $display("FAIL flush idle_pulse got %b want 1", flush_done); end
    flush = 1'b0;
    sram_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(24'h000300 + 24'(i), 16'h3000 + 16'(i));
    flush = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      sram_ready = (k % 2 == 0);
      #1;
      n_cmp += 2;
      if (frag_ready !== 1'b0) begin n_fail++; $display("FAIL flush frag_ready%0d got %b want 0", k, frag_ready); end
      if (flush_done !== (k == 4)) begin n_fail++; $display("FAIL flush done%0d got %b want %b", k, flush_done, (k == 4)); end
      if (flush_done === 1'b1) pulses++;
      tick();
    end
    flush = 1'b0;
    sram_ready = 1'b0;
    #1;
    n_cmp += 4;
    if (pulses != 1) begin n_fail++; $display("FAIL flush pulse_count got %0d want 1", pulses); end
    if (idle !== 1'b1) begin n_fail++; $display("FAIL flush idle_after got %b want 1", idle); end
    if (flush_done !== 1'b0) begin n_fail++; $display("FAIL flush done_after got %b want 0", flush_done); end
    if (frag_ready !== 1'b1) begin n_fail++; $display("FAIL flush ready_after got %b want 1", frag_ready); end
  endtask

  task automatic test_coalesce();
    int exp_n;
    logic [15:0] exp_last;
    wq_addr.delete(); wq_z.delete();
    sram_ready = 1'b0;
    push_one(24'h000030, 16'h1111);
    push_one(24'h000040, 16'h2222);
    push_one(24'h000040, 16'h3333);
    drain("coalesce");
`ifdef ZBUF_WB_COALESCE_EN
    exp_n = 2;
`else
    exp_n = 3;
`endif
    exp_last = 16'h3333;
    n_cmp++;
    if (wq_z.size() != exp_n) begin n_fail++; $display("FAIL coalesce writes got %0d want %0d", wq_z.size(), exp_n); end
    else begin
      n_cmp += 2;
      if (wq_z[exp_n-1] !== exp_last) begin n_fail++; $display("FAIL coalesce last_z got %h want %h", wq_z[exp_n-1], exp_last); end
      if (wq_addr[exp_n-1] !== 24'h000040) begin n_fail++; $display("FAIL coalesce last_addr got %h want 000040", wq_addr[exp_n-1]); end
    end
  endtask

  task automatic test_back_to_back();
    wq_addr.delete(); wq_z.delete();
    sram_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(24'h000500 + 24'(i), 16'h5000 + 16'(i));
    sram_ready = 1'b1;
    frag_valid = 1'b1; frag_addr = 24'h000600; frag_z = 16'h6000;
    #1;
    n_cmp++;
    if (frag_ready !== 1'b0) begin n_fail++; $display("FAIL b2b ready_full_pop got %b want 0", frag_ready); end
    tick();
    n_cmp++;
    if (frag_ready !== 1'b1) begin n_fail++; $display("FAIL b2b ready_after_pop got %b want 1", frag_ready); end
    tick();
    frag_valid = 1'b0;
    drain("b2b");
    n_cmp++;
    if (wq_z.size() != 5) begin n_fail++; $display("FAIL b2b writes got %0d want 5", wq_z.size()); end
    else begin
      n_cmp += 2;
      if (wq_z[4] !== 16'h6000) begin n_fail++; $display("FAIL b2b last_z got %h want 6000", wq_z[4]); end
      if (wq_z[1] !== 16'h5001) begin n_fail++; $display("FAIL b2b second_z got %h want 5001", wq_z[1]); end
    end
  endtask

  task automatic test_reset_abort();
    sram_ready = 1'b0;
    push_one(24'h000900, 16'h9999);
    n_cmp++;
    if (sram_req !== 1'b1) begin n_fail++; $display("FAIL abort req_before got %b want 1", sram_req); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 2;
    if (sram_req !== 1'b0) begin n_fail++; $display("FAIL abort req_async got %b want 0", sram_req); end
    if (idle !== 1'b1) begin n_fail++; $display("FAIL abort idle got %b want 1", idle); end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (sram_req !== 1'b0) begin n_fail++; $display("FAIL abort req_after got %b want 0", sram_req); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_lookup();
    test_no_zwrite();
    test_flush();
    test_coalesce();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
